// File: rtl/morse_pkg.sv
// Shared types for the Morse key front-end and the downstream pattern decoder.
package morse_pkg;

    localparam int unsigned MaxSymDefault = 5;
    localparam int unsigned SymLenW       = 3;
    localparam int unsigned CntW          = 8;

    typedef enum logic [2:0] {
        StIdle,
        StPress,
        StGap,
        StLetter,
        StWaitWord
    } seq_state_e;

    // Token layout as seen by the decoder at the default letter size.
    typedef struct packed {
        logic                     space;
        logic                     err;
        logic [SymLenW-1:0]       len;
        logic [MaxSymDefault-1:0] bits;
    } sym_token_t;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == '1) ? v : v + CntW'(1);
    endfunction

endpackage

// File: rtl/morse_key_conditioner.sv
// Key synchronizer with optional debounce filter producing filtered rise/fall pulses.
// The filter is present only when MORSE_SEQ_DEBOUNCE_EN is defined.
module morse_key_conditioner #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ena_i,
    input  logic key_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q, level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef MORSE_SEQ_DEBOUNCE_EN
    localparam int unsigned DbW = $clog2(DB_CYCLES + 1);

    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           level_d, flip;
    logic           rise_q, fall_q;

    // A new level is accepted after DB_CYCLES consecutive differing samples.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        flip     = 1'b0;
        if (ena_i) begin
            if (sync2_q == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DbW'(DB_CYCLES - 1)) begin
                flip     = 1'b1;
                level_d  = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            rise_q   <= flip & sync2_q;
            fall_q   <= flip & ~sync2_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    logic unused_db;
    assign unused_db = ^DB_CYCLES;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else if (ena_i) begin
            level_q <= sync2_q;
        end
    end

    assign rise_o = ena_i & sync2_q & ~level_q;
    assign fall_o = ena_i & ~sync2_q & level_q;
`endif

endmodule

// File: rtl/morse_key_sequencer.sv
// Morse key front-end: times presses/gaps, assembles letters and word spaces into a one-entry slot.
// Define MORSE_SEQ_DEBOUNCE_EN to include the key debounce filter.
module morse_key_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 10000,
    parameter int unsigned DB_CYCLES  = 16,
    parameter int unsigned DASH_MIN   = 3,
    parameter int unsigned LETTER_GAP = 3,
    parameter int unsigned WORD_GAP   = 7,
    parameter int unsigned MAX_SYM    = MaxSymDefault
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               key,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic [MAX_SYM-1:0] sym_bits,
    output logic [SymLenW-1:0] sym_len,
    output logic               sym_space,
    output logic               sym_err,
    output logic               busy
);

    localparam int unsigned PrescW = $clog2(TICK_DIV + 1);

    logic rise, fall, tick;

    morse_key_conditioner #(
        .DB_CYCLES(DB_CYCLES)
    ) u_cond (
        .clk   (clk),
        .rst   (rst),
        .ena_i (ena),
        .key_i (key),
        .rise_o(rise),
        .fall_o(fall)
    );

    logic [PrescW-1:0] presc_q, presc_d;

    assign tick = ena && (presc_q == PrescW'(TICK_DIV - 1));

    always_comb begin
        presc_d = presc_q;
        if (ena) begin
            if (rise || fall || tick) presc_d = '0;
            else                      presc_d = presc_q + PrescW'(1);
        end
    end

    seq_state_e         state_q, state_d;
    logic [CntW-1:0]    press_q, press_d, gap_q, gap_d;
    logic [MAX_SYM-1:0] acc_bits_q, acc_bits_d;
    logic [SymLenW-1:0] acc_len_q, acc_len_d;
    logic               acc_err_q, acc_err_d;
    logic               valid_q, valid_d;
    logic [MAX_SYM-1:0] bits_q, bits_d;
    logic [SymLenW-1:0] len_q, len_d;
    logic               space_q, space_d;
    logic               err_q, err_d;
    logic               pend_q, pend_d;
    logic               slot_free, dash, word_evt;

    // A handshake in this cycle frees the slot for a load on the same edge.
    assign slot_free = !valid_q || sym_ready;
    assign dash      = (press_q >= CntW'(DASH_MIN));

    always_comb begin
        state_d    = state_q;
        press_d    = press_q;
        gap_d      = gap_q;
        acc_bits_d = acc_bits_q;
        acc_len_d  = acc_len_q;
        acc_err_d  = acc_err_q;
        valid_d    = valid_q;
        bits_d     = bits_q;
        len_d      = len_q;
        space_d    = space_q;
        err_d      = err_q;
        pend_d     = pend_q;
        word_evt   = 1'b0;

        if (ena) begin
            if (valid_q && sym_ready) valid_d = 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StPress;
                        press_d = '0;
                    end
                end
                StPress: begin
                    if (fall) begin
                        if (acc_len_q == SymLenW'(MAX_SYM)) begin
                            acc_err_d = 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < MAX_SYM; i++) begin
                                if (acc_len_q == SymLenW'(i)) acc_bits_d[i] = dash;
                            end
                            acc_len_d = acc_len_q + SymLenW'(1);
                        end
                        gap_d   = '0;
                        state_d = StGap;
                    end else if (tick) begin
                        press_d = sat_inc(press_q);
                    end
                end
                StGap: begin
                    if (rise) begin
                        state_d = StPress;
                        press_d = '0;
                        gap_d   = '0;
                    end else if (gap_q == CntW'(LETTER_GAP)) begin
                        state_d = StLetter;
                    end else if (tick) begin
                        gap_d = sat_inc(gap_q);
                    end
                end
                StLetter: begin
                    // An older pending space takes the slot first.
                    if (slot_free && !pend_q) begin
                        valid_d    = 1'b1;
                        bits_d     = acc_bits_q;
                        len_d      = acc_len_q;
                        err_d      = acc_err_q;
                        space_d    = 1'b0;
                        acc_bits_d = '0;
                        acc_len_d  = '0;
                        acc_err_d  = 1'b0;
                        state_d    = StWaitWord;
                    end
                end
                StWaitWord: begin
                    if (rise) begin
                        state_d = StPress;
                        press_d = '0;
                        gap_d   = '0;
                    end else if (gap_q == CntW'(WORD_GAP)) begin
                        word_evt = 1'b1;
                        state_d  = StIdle;
                    end else if (tick) begin
                        gap_d = sat_inc(gap_q);
                    end
                end
                default: state_d = StIdle;
            endcase

            if (pend_q && slot_free) begin
                valid_d = 1'b1;
                bits_d  = '0;
                len_d   = '0;
                err_d   = 1'b0;
                space_d = 1'b1;
                pend_d  = 1'b0;
            end

            if (word_evt) begin
                if (slot_free && !pend_q) begin
                    valid_d = 1'b1;
                    bits_d  = '0;
                    len_d   = '0;
                    err_d   = 1'b0;
                    space_d = 1'b1;
                end else begin
                    pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            state_q    <= StIdle;
            press_q    <= '0;
            gap_q      <= '0;
            acc_bits_q <= '0;
            acc_len_q  <= '0;
            acc_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            bits_q     <= '0;
            len_q      <= '0;
            space_q    <= 1'b0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            state_q    <= state_d;
            press_q    <= press_d;
            gap_q      <= gap_d;
            acc_bits_q <= acc_bits_d;
            acc_len_q  <= acc_len_d;
            acc_err_q  <= acc_err_d;
            valid_q    <= valid_d;
            bits_q     <= bits_d;
            len_q      <= len_d;
            space_q    <= space_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
        end
    end

    assign sym_valid = valid_q;
    assign sym_bits  = bits_q;
    assign sym_len   = len_q;
    assign sym_space = space_q;
    assign sym_err   = err_q;
    assign busy      = (state_q != StIdle) | valid_q | pend_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Self-checking bench for morse_key_sequencer: table-driven letters plus stall, bounce, ena and reset cases.
module tb_morse_key_sequencer;

    localparam int unsigned TickDiv  = 4;
    localparam int unsigned DbCycles = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       key = 1'b0;
    logic       sym_ready = 1'b1;
    logic       sym_valid, sym_space, sym_err, busy;
    logic [4:0] sym_bits;
    logic [2:0] sym_len;

    always #5 clk = ~clk;

    morse_key_sequencer #(
        .TICK_DIV  (TickDiv),
        .DB_CYCLES (DbCycles),
        .DASH_MIN  (3),
        .LETTER_GAP(3),
        .WORD_GAP  (7),
        .MAX_SYM   (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .key      (key),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sym_bits (sym_bits),
        .sym_len  (sym_len),
        .sym_space(sym_space),
        .sym_err  (sym_err),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_tokens = 0;
    logic [9:0] sb_q[$];

    localparam logic [9:0] SpaceTok = 10'h200;

    wire [9:0] dut_tok = {sym_space, sym_err, sym_len, sym_bits};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted token is compared with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && sym_valid) begin
            if (sym_ready) begin
                n_tokens++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_token: got 0x%0h, expected none", dut_tok);
                end else begin
                    check("token", 32'(dut_tok), 32'(sb_q.pop_front()));
                end
            end else if (sb_q.size() != 0) begin
                check("stall_hold", 32'(dut_tok), 32'(sb_q[0]));
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_letter(input logic [7:0] pat, input int nsym, input int gap_ticks);
        for (int i = 0; i < nsym; i++) begin
            key = 1'b1;
            clks((pat[i] ? 4 : 1) * TickDiv);
            key = 1'b0;
            clks(((i == nsym - 1) ? gap_ticks : 1) * TickDiv);
        end
    endtask

    typedef struct {
        logic [7:0] pat;
        int         nsym;
        int         gap;
        logic [9:0] exp_tok;
        bit         exp_space;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int tok_before;

        // {space, err, len, bits}
        vecs[0] = '{8'b0000_0000, 1, 5,  {1'b0, 1'b0, 3'd1, 5'b00000}, 1'b0}; // E
        vecs[1] = '{8'b0000_0101, 4, 5,  {1'b0, 1'b0, 3'd4, 5'b00101}, 1'b0}; // C
        vecs[2] = '{8'b0000_0101, 4, 10, {1'b0, 1'b0, 3'd4, 5'b00101}, 1'b1}; // C + space
        vecs[3] = '{8'b0000_0000, 6, 5,  {1'b0, 1'b1, 3'd5, 5'b00000}, 1'b0}; // overflow
        vecs[4] = '{8'b0000_0010, 2, 10, {1'b0, 1'b0, 3'd2, 5'b00010}, 1'b1}; // A + space
        vecs[5] = '{8'b0001_1111, 5, 10, {1'b0, 1'b0, 3'd5, 5'b11111}, 1'b1}; // 0 + space

        clks(3);
        check("reset_valid", 32'(sym_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_token", 32'(dut_tok), 32'd0);
        rst = 1'b0;
        clks(2);
        check("idle_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 6; v++) begin
            sb_q.push_back(vecs[v].exp_tok);
            if (vecs[v].exp_space) sb_q.push_back(SpaceTok);
            send_letter(vecs[v].pat, vecs[v].nsym, vecs[v].gap);
        end
        check("table_drained", 32'(sb_q.size()), 32'd0);

        // Two letters while the decoder is not ready: the second stalls, nothing is lost.
        sym_ready = 1'b0;
        sb_q.push_back({1'b0, 1'b0, 3'd1, 5'b00000});
        sb_q.push_back({1'b0, 1'b0, 3'd1, 5'b00001});
        sb_q.push_back(SpaceTok);
        send_letter(8'b0, 1, 5);
        send_letter(8'b1, 1, 10);
        clks(2 * TickDiv);
        check("stall_valid", 32'(sym_valid), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_len", 32'(sym_len), 32'd1);
        check("stall_bits", 32'(sym_bits), 32'd0);
        sym_ready = 1'b1;
        clks(1);
        check("zero_bubble_valid", 32'(sym_valid), 32'd1);
        check("zero_bubble_bits", 32'(sym_bits), 32'd1);
        clks(12 * TickDiv);
        check("stall_drained", 32'(sb_q.size()), 32'd0);

`ifdef MORSE_SEQ_DEBOUNCE_EN
        // A one-cycle bounce inside a dash must not split it.
        sb_q.push_back({1'b0, 1'b0, 3'd1, 5'b00001});
        sb_q.push_back(SpaceTok);
        key = 1'b1;
        clks(8);
        key = 1'b0;
        clks(1);
        key = 1'b1;
        clks(8);
        key = 1'b0;
        clks(12 * TickDiv);
        check("bounce_drained", 32'(sb_q.size()), 32'd0);
`endif

        // With ena low the key is ignored entirely.
        tok_before = n_tokens;
        ena = 1'b0;
        key = 1'b1;
        clks(5 * TickDiv);
        key = 1'b0;
        clks(5 * TickDiv);
        check("frozen_busy", 32'(busy), 32'd0);
        ena = 1'b1;
        clks(12 * TickDiv);
        check("frozen_no_token", 32'(n_tokens), 32'(tok_before));

        // Reset mid-press drops the partial letter.
        tok_before = n_tokens;
        key = 1'b1;
        clks(2 * TickDiv);
        check("press_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midreset_valid", 32'(sym_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_token", 32'(dut_tok), 32'd0);
        key = 1'b0;
        clks(4);
        rst = 1'b0;
        clks(12 * TickDiv);
        check("reset_no_token", 32'(n_tokens), 32'(tok_before));
        check("final_busy", 32'(busy), 32'd0);
        check("final_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
